// File: rtl/fib_pkg.sv
// Shared types and widths for the iterative Fibonacci accelerator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fib_pkg;

   localparam int N_W   = 8;
   localparam int RES_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fib_state_t;

   typedef logic [RES_W-1:0] fib_res_t;
   typedef logic [N_W-1:0]   fib_idx_t;

endpackage

// File: rtl/fib_acc.sv
// Iterative Fibonacci engine: computes F(n) mod 2^RES_W, one addition per clock.
// Latency: 1 cycle accept->valid for n<=1, n cycles for n>=2 (worst case 255).
// Backpressure: single transaction in flight; result held in DONE until rdy_out, input refused until then.
module fib_acc
   import fib_pkg::*;
(
   input  logic             CLK,
   input  logic             rst,
   input  logic [N_W-1:0]   fib_in,
   input  logic             vld_in,
   output logic             rdy_in,
   output logic             vld_out,
   output logic [RES_W-1:0] fib_out,
   input  logic             rdy_out
);

   fib_state_t state_q, state_d;
   fib_idx_t   n_q, n_d;
   fib_idx_t   cnt_q, cnt_d;
   fib_res_t   a_q, a_d;
   fib_res_t   b_q, b_d;
   fib_res_t   res_q, res_d;
   fib_res_t   sum;

   // Single adder shared by the iteration step and the final result load.
   assign sum = a_q + b_q;

   // State and datapath registers; reset discards any in-flight work.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= fib_res_t'(1);
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   // Next-state and datapath update; n<=1 short-circuits straight to DONE.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (vld_in) begin
               n_d = fib_in;
               if (fib_in == fib_idx_t'(0)) begin
                  res_d   = '0;
                  state_d = DONE;
               end else if (fib_in == fib_idx_t'(1)) begin
                  res_d   = fib_res_t'(1);
                  state_d = DONE;
               end else begin
                  a_d     = '0;
                  b_d     = fib_res_t'(1);
                  cnt_d   = fib_idx_t'(1);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            a_d   = b_q;
            b_d   = sum;
            cnt_d = cnt_q + fib_idx_t'(1);
            // cnt tracks the index of b; the edge producing F(n) is cnt == n-1.
            if (cnt_q == n_q - fib_idx_t'(1)) begin
               res_d   = sum;
               state_d = DONE;
            end
         end
         DONE: begin
            if (rdy_out) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rdy_in  = (state_q == IDLE);
   assign vld_out = (state_q == DONE);
   assign fib_out = res_q;

endmodule

// File: tb/tb_fib_acc.sv
// Directed bench for fib_acc: table of {n, expected F(n), latency} plus hand sequences.
// Inputs driven and outputs sampled on the falling edge.
// Accept/consume handshakes are counted at the rising edge to catch lost or duplicated transactions.
module tb_fib_acc;

   logic        CLK = 1'b0;
   logic        rst;
   logic [7:0]  fib_in;
   logic        vld_in;
   logic        rdy_in;
   logic        vld_out;
   logic [31:0] fib_out;
   logic        rdy_out;

   int vec_cnt = 0;
   int err_cnt = 0;
   int acc_cnt = 0;
   int out_cnt = 0;

   typedef struct {
      logic [7:0]  n;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[7];

   fib_acc dut (
      .CLK     (CLK),
      .rst     (rst),
      .fib_in  (fib_in),
      .vld_in  (vld_in),
      .rdy_in  (rdy_in),
      .vld_out (vld_out),
      .fib_out (fib_out),
      .rdy_out (rdy_out)
   );

   always #5 CLK = ~CLK;

   // Handshake counters.
   always @(posedge CLK) begin
      if (!rst && vld_in && rdy_in)   acc_cnt++;
      if (!rst && vld_out && rdy_out) out_cnt++;
   end

   function automatic logic [31:0] fib_ref(input int n);
      logic [31:0] a, b, t;
      a = 32'd0;
      b = 32'd1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Wait (bounded) for vld_out after an accept edge; returns edges counted since accept.
   task automatic wait_vld(input int start, output int lat);
      lat = start;
      while (!vld_out && lat < 400) begin
         @(negedge CLK);
         lat++;
      end
   endtask

   // One transaction: present n for one cycle, check latency and result, consume once.
   task automatic run_txn(input string name, input logic [7:0] n, input logic [31:0] exp, input int exp_lat);
      int lat;
      int acc0, out0;
      acc0 = acc_cnt;
      out0 = out_cnt;
      check({name, " rdy_in idle"}, rdy_in, 1);
      fib_in = n;
      vld_in = 1'b1;
      @(negedge CLK);
      vld_in = 1'b0;
      wait_vld(1, lat);
      check({name, " latency"}, lat, exp_lat);
      check({name, " fib_out"}, fib_out, exp);
      rdy_out = 1'b1;
      @(negedge CLK);
      rdy_out = 1'b0;
      check({name, " one accept"}, acc_cnt - acc0, 1);
      check({name, " one consume"}, out_cnt - out0, 1);
      check({name, " back to idle"}, {rdy_in, vld_out}, 2'b10);
   endtask

   initial begin
      int lat;
      int acc0, out0;
      logic stable_ok;

      tbl[0] = '{n: 8'd0,   exp: 32'd0,          lat: 1};
      tbl[1] = '{n: 8'd1,   exp: 32'd1,          lat: 1};
      tbl[2] = '{n: 8'd2,   exp: 32'd1,          lat: 2};
      tbl[3] = '{n: 8'd10,  exp: 32'd55,         lat: 10};
      tbl[4] = '{n: 8'd47,  exp: 32'd2971215073, lat: 47};
      tbl[5] = '{n: 8'd48,  exp: 32'd512559680,  lat: 48};
      tbl[6] = '{n: 8'd255, exp: fib_ref(255),   lat: 255};

      rst     = 1'b1;
      vld_in  = 1'b0;
      fib_in  = 8'd0;
      rdy_out = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset rdy_in", rdy_in, 1);
      check("reset vld_out", vld_out, 0);
      check("reset fib_out", fib_out, 0);
      rst = 1'b0;
      @(negedge CLK);

      // Basic: n=6 with vld_in held for two cycles -> single accept.
      acc0 = acc_cnt;
      fib_in = 8'd6;
      vld_in = 1'b1;
      @(negedge CLK);
      check("basic rdy_in low in CALC", rdy_in, 0);
      @(negedge CLK);
      vld_in = 1'b0;
      wait_vld(2, lat);
      check("basic latency", lat, 6);
      check("basic fib_out", fib_out, 8);
      check("basic single accept", acc_cnt - acc0, 1);
      rdy_out = 1'b1;
      @(negedge CLK);
      rdy_out = 1'b0;
      check("basic idle after consume", {rdy_in, vld_out}, 2'b10);

      // Boundary and width-limit table.
      for (int i = 0; i < 7; i++) begin
         run_txn($sformatf("tbl n=%0d", tbl[i].n), tbl[i].n, tbl[i].exp, tbl[i].lat);
      end

      // Backpressure: hold result 20 cycles while a new request is offered.
      acc0 = acc_cnt;
      out0 = out_cnt;
      fib_in = 8'd7;
      vld_in = 1'b1;
      @(negedge CLK);
      fib_in = 8'd3;
      wait_vld(1, lat);
      check("bp latency", lat, 7);
      stable_ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (!(vld_out === 1'b1 && fib_out === 32'd13 && rdy_in === 1'b0)) stable_ok = 1'b0;
         fib_in = 8'(c);
         @(negedge CLK);
      end
      vld_in = 1'b0;
      check("bp held stable", stable_ok, 1);
      check("bp no extra accept", acc_cnt - acc0, 1);
      check("bp no consume yet", out_cnt - out0, 0);
      rdy_out = 1'b1;
      @(negedge CLK);
      rdy_out = 1'b0;
      @(negedge CLK);
      check("bp single consume", out_cnt - out0, 1);
      check("bp idle", {rdy_in, vld_out}, 2'b10);

      // Reset in the middle of CALC for n=30.
      fib_in = 8'd30;
      vld_in = 1'b1;
      @(negedge CLK);
      vld_in = 1'b0;
      repeat (10) @(negedge CLK);
      check("midrst still busy", {rdy_in, vld_out}, 2'b00);
      rst = 1'b1;
      @(negedge CLK);
      rst = 1'b0;
      check("midrst rdy_in", rdy_in, 1);
      check("midrst vld_out", vld_out, 0);
      check("midrst fib_out", fib_out, 0);
      run_txn("after rst n=5", 8'd5, 32'd5, 5);

      // Back-to-back sweep n=1..20.
      acc0 = acc_cnt;
      out0 = out_cnt;
      for (int n = 1; n <= 20; n++) begin
         run_txn($sformatf("sweep n=%0d", n), 8'(n), fib_ref(n), (n <= 1) ? 1 : n);
      end
      check("sweep accepts", acc_cnt - acc0, 20);
      check("sweep consumes", out_cnt - out0, 20);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/fib_acc.md
Name: fib_acc

Overview:
Iterative Fibonacci accelerator. Accepts an 8-bit index n on a valid/ready input channel and computes F(n) with one addition per clock, where F(0)=0 and F(1)=1. Returns the 32-bit result on a valid/ready output channel. Single-transaction engine: it accepts no new input until the current result has been consumed. Sits as a leaf compute block behind any valid/ready producer and consumer.

Parameters:
N_W, 8, width of index input fib_in
RES_W, 32, width of result fib_out; arithmetic is modulo 2^RES_W

Ports:
CLK  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
fib_in  input  N_W  Fibonacci index n; sampled on input handshake
vld_in  input  1  producer asserts when fib_in is valid
rdy_in  output  1  block can accept an index (high only in IDLE)
vld_out  output  1  fib_out holds a valid result (high only in DONE)
fib_out  output  RES_W  result F(n) mod 2^RES_W
rdy_out  input  1  consumer ready; output handshake = vld_out && rdy_out

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (rst).
- Reset: state=IDLE, rdy_in=1, vld_out=0, fib_out=0, internal a=0, b=1, cnt=0. Reset takes priority over all other activity, including mid-CALC and mid-DONE; any in-flight result is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE: rdy_in=1, vld_out=0. On an edge with vld_in=1, latch n=fib_in.
  - n=0: load result=0, go to DONE.
  - n=1: load result=1, go to DONE.
  - n>=2: a<=0, b<=1, cnt<=1, go to CALC.
- CALC: rdy_in=0, vld_out=0. Each edge: a<=b, b<=a+b (truncate to RES_W), cnt<=cnt+1. On the edge where cnt==n-1, load result with the new b and go to DONE. CALC occupies exactly n-1 cycles.
- DONE: rdy_in=0, vld_out=1, fib_out=result, held stable. On an edge with rdy_out=1, go to IDLE. The output is consumed exactly once. vld_out is combinationally independent of rdy_out.
- Latency from accept edge to vld_out high: 1 cycle for n<=1; n cycles for n>=2. Worst case n=255 gives 255 cycles.
- fib_out is registered. It holds the last result after leaving DONE and is only meaningful while vld_out=1.
- vld_in is ignored while rdy_in=0. A producer holding vld_in high across several cycles yields exactly one transaction. A new input can be accepted no earlier than the cycle after the output handshake, because IDLE follows DONE.
- Overflow: n>=48 wraps silently modulo 2^32. No error flag.
- rdy_out asserted outside DONE has no effect.

Decomposition:
- Package fib_pkg holds: parameters N_W and RES_W; state enum typedef fib_state_t {IDLE, CALC, DONE}; a typedef for the result word.
- No sub-module. The FSM and datapath (a, b, cnt, result registers) fit naturally in one module.

Test Plan:
- Basic: reset 2 cycles, then n=6 with vld_in held 2 cycles. Require exactly one accept, vld_out rising 6 cycles after accept, and fib_out=8. A 1-cycle rdy_out returns the block to IDLE with rdy_in=1.
- Boundaries: n=0 -> 0, n=1 -> 1, n=2 -> 1, each with the specified latency. n=10 -> 55.
- Width limits: n=47 -> 2971215073. n=48 -> 512559680 (wrapped). n=255 -> completes in 255 cycles with the truncated value matching the 32-bit reference model.
- Backpressure: hold rdy_out=0 for 20 cycles after vld_out rises. Require vld_out and fib_out stable, rdy_in=0, and new vld_in/fib_in ignored. Release rdy_out and require a single consume.
- Reset mid-operation: assert rst during CALC of n=30. Next cycle require IDLE, rdy_in=1, vld_out=0, fib_out=0. Then n=5 -> 5 correctly.
- Back-to-back sweep: n=1..20, with the result checked against the reference model each time, and no lost or duplicated transactions.
